// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 5..9 data bits, optional parity, start-glitch rejection; UART_RX_MAJORITY_EN adds 2-of-3 voting at sample points.
// Latency: rx_rdy rises ~CLKS_PER_BIT*(DATA_BITS+PARITY_EN+1)+HALF+3 clk after the start edge.
// Backpressure: none; rx_data/flags are held until the next frame overwrites them.
module uart_rx_os #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_rdy,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_END = IDX_W'(DATA_BITS - 1);
    localparam logic             ODD_BIT = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 rx_m;
    logic                 rx_s;
    logic                 rx_prev;
    logic                 sample_bit;

    // Resetting the synchroniser to 0 means a line held low across reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m    <= 1'b0;
            rx_s    <= 1'b0;
            rx_prev <= 1'b0;
        end else begin
            rx_m    <= rx_in;
            rx_s    <= rx_m;
            rx_prev <= rx_s;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic       rx_prev2;
    logic [2:0] rx_hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_prev2 <= 1'b0;
        end else begin
            rx_prev2 <= rx_prev;
        end
    end

    assign rx_hist    = {rx_prev2, rx_prev, rx_s};
    assign sample_bit = (rx_hist[0] & rx_hist[1]) | (rx_hist[0] & rx_hist[2]) | (rx_hist[1] & rx_hist[2]);
`else
    assign sample_bit = rx_s;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            rx_data    <= '0;
            rx_rdy     <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_rdy <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (rx_prev && !rx_s) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == CNT_MID) begin
                        cnt <= '0;
                        if (sample_bit) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            idx   <= '0;
                            state <= DATA;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CNT_END) begin
                        cnt        <= '0;
                        shreg[idx] <= sample_bit;
                        if (idx == IDX_END) begin
                            state <= (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (cnt == CNT_END) begin
                        cnt     <= '0;
                        par_bit <= sample_bit;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    // Leave at the stop midpoint so a following start edge is never missed.
                    if (cnt == CNT_END) begin
                        cnt        <= '0;
                        rx_data    <= shreg;
                        frame_err  <= ~sample_bit;
                        parity_err <= (PARITY_EN != 0) && ((^shreg ^ par_bit ^ ODD_BIT) != 1'b0);
                        rx_rdy     <= 1'b1;
                        state      <= IDLE;
                        busy       <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: default 8N1 instance plus a 7-bit even-parity instance.
module tb_uart_rx_os;

    typedef struct packed {
        logic [8:0] d;
        logic       fe;
        logic       pe;
    } rec_t;

`ifdef UART_RX_MAJORITY_EN
    localparam bit GLITCH = 1'b1;
`else
    localparam bit GLITCH = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx0 = 1'b1;
    logic       rx1 = 1'b1;
    logic [7:0] rx_data0;
    logic [6:0] rx_data1;
    logic       rx_rdy0, rx_rdy1, fe0, fe1, pe0, pe1, busy0, busy1;

    rec_t  exp0[$], obs0[$], exp1[$], obs1[$];
    rec_t  m0, m1;
    int    n_cmp = 0;
    int    n_bad = 0;
    int    wide0 = 0;
    bit    rdy_prev0 = 1'b0;
    bit    busy_all0;
    longint t_fall0 = 0;
    longint t_rdy0 = 0;

    uart_rx_os dut0 (
        .clk(clk), .rst_n(rst_n), .rx_in(rx0), .rx_data(rx_data0), .rx_rdy(rx_rdy0),
        .frame_err(fe0), .parity_err(pe0), .busy(busy0)
    );

    uart_rx_os #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .rx_in(rx1), .rx_data(rx_data1), .rx_rdy(rx_rdy1),
        .frame_err(fe1), .parity_err(pe1), .busy(busy1)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_rdy0) begin
            m0.d = {1'b0, rx_data0}; m0.fe = fe0; m0.pe = pe0;
            obs0.push_back(m0);
            t_rdy0 = $time;
            if (rdy_prev0) wide0++;
        end
        rdy_prev0 = rx_rdy0;
        if (rx_rdy1) begin
            m1.d = {2'b00, rx_data1}; m1.fe = fe1; m1.pe = pe1;
            obs1.push_back(m1);
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int which, input logic v);
        if (which == 0) rx0 = v;
        else            rx1 = v;
    endtask

    // Drives one frame and pushes the expected record for it.
    task automatic send(input int which, input logic [8:0] data, input int nbits,
                        input bit has_par, input logic par, input logic stop, input bit glitch);
        logic [11:0] bits;
        rec_t        e;
        int          n;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < nbits; i++) bits[1+i] = data[i];
        n = 1 + nbits;
        if (has_par) begin bits[n] = par; n++; end
        bits[n] = stop;
        n++;
        e.d  = data;
        e.fe = ~stop;
        e.pe = has_par ? ((^data) ^ par) : 1'b0;
        if (which == 0) exp0.push_back(e);
        else            exp1.push_back(e);
        for (int b = 0; b < n; b++) begin
            drive(which, bits[b]);
            if (b == 0 && which == 0) t_fall0 = $time;
            if (glitch && b >= 1 && b <= nbits) begin
                hold(8); drive(which, ~bits[b]); hold(1); drive(which, bits[b]); hold(7);
            end else begin
                hold(8);
                if (which == 0) busy_all0 &= busy0;
                hold(8);
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; rx0 = 1'b1; rx1 = 1'b1;
        hold(3);
        n_cmp++; if (rx_data0 !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", rx_data0); end
        n_cmp++; if (rx_rdy0 !== 1'b0) begin n_bad++; $display("FAIL reset_rdy: got %b want 0", rx_rdy0); end
        n_cmp++; if (fe0 !== 1'b0) begin n_bad++; $display("FAIL reset_fe: got %b want 0", fe0); end
        n_cmp++; if (pe0 !== 1'b0) begin n_bad++; $display("FAIL reset_pe: got %b want 0", pe0); end
        n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy0); end
        n_cmp++; if ({rx_data1, rx_rdy1, fe1, pe1, busy1} !== 11'h0) begin
            n_bad++; $display("FAIL reset_dut1: got %h want 000", {rx_data1, rx_rdy1, fe1, pe1, busy1});
        end
        rst_n = 1'b1;
        hold(8);
        n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL idle_after_reset: busy got %b want 0", busy0); end
    endtask

    task automatic test_basic;
        rec_t e, o;
        int   lat;
        busy_all0 = 1'b1;
        send(0, 9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 300 && obs0.size() < exp0.size(); k++) hold(1);
        n_cmp++; if (obs0.size() != 1) begin n_bad++; $display("FAIL basic_count: got %0d pulses want 1", obs0.size()); end
        lat = int'((t_rdy0 - 5 - t_fall0 + 9) / 10);
        n_cmp++; if (lat < 152 || lat > 156) begin n_bad++; $display("FAIL basic_latency: got %0d clk want 152..156", lat); end
        n_cmp++; if (busy_all0 !== 1'b1) begin n_bad++; $display("FAIL basic_busy: busy dropped during frame, want 1"); end
        n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL basic_busy_end: got %b want 0", busy0); end
        while (exp0.size() > 0) begin
            e = exp0.pop_front(); n_cmp++;
            if (obs0.size() == 0) begin n_bad++; $display("FAIL basic_frame: no frame, want d=%h", e.d); end
            else begin
                o = obs0.pop_front();
                if (o !== e) begin n_bad++; $display("FAIL basic_frame: got d=%h fe=%b pe=%b want d=%h fe=%b pe=%b", o.d, o.fe, o.pe, e.d, e.fe, e.pe); end
            end
        end
        obs0.delete();
    endtask

    task automatic test_frame_err;
        rec_t e, o;
        send(0, 9'h03C, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(0, 1'b1); hold(16);
        send(0, 9'h055, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 300 && obs0.size() < exp0.size(); k++) hold(1);
        while (exp0.size() > 0) begin
            e = exp0.pop_front(); n_cmp++;
            if (obs0.size() == 0) begin n_bad++; $display("FAIL frame_err: no frame, want d=%h", e.d); end
            else begin
                o = obs0.pop_front();
                if (o !== e) begin n_bad++; $display("FAIL frame_err: got d=%h fe=%b pe=%b want d=%h fe=%b pe=%b", o.d, o.fe, o.pe, e.d, e.fe, e.pe); end
            end
        end
        n_cmp++; if (obs0.size() != 0) begin n_bad++; $display("FAIL frame_err_extra: got %0d extra frames want 0", obs0.size()); end
        obs0.delete();
    endtask

    task automatic test_parity;
        rec_t e, o;
        send(1, 9'h041, 7, 1'b1, 1'b0, 1'b1, 1'b0);
        hold(16);
        send(1, 9'h041, 7, 1'b1, 1'b1, 1'b1, 1'b0);
        hold(16);
        send(1, 9'h043, 7, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 300 && obs1.size() < exp1.size(); k++) hold(1);
        while (exp1.size() > 0) begin
            e = exp1.pop_front(); n_cmp++;
            if (obs1.size() == 0) begin n_bad++; $display("FAIL parity: no frame, want d=%h pe=%b", e.d, e.pe); end
            else begin
                o = obs1.pop_front();
                if (o !== e) begin n_bad++; $display("FAIL parity: got d=%h fe=%b pe=%b want d=%h fe=%b pe=%b", o.d, o.fe, o.pe, e.d, e.fe, e.pe); end
            end
        end
        obs1.delete();
    endtask

    task automatic test_false_start;
        drive(0, 1'b0); hold(3);
        drive(0, 1'b1); hold(2);
        n_cmp++; if (busy0 !== 1'b1) begin n_bad++; $display("FAIL false_start_busy: got %b want 1", busy0); end
        hold(7);
        n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL false_start_idle: busy got %b want 0 within 12 clk", busy0); end
        hold(200);
        n_cmp++; if (obs0.size() != 0) begin n_bad++; $display("FAIL false_start_rdy: got %0d frames want 0", obs0.size()); end
        obs0.delete();
    endtask

    task automatic test_back_to_back;
        rec_t e, o;
        send(0, 9'h000, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        send(0, 9'h0FF, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        send(0, 9'h081, 8, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 300 && obs0.size() < exp0.size(); k++) hold(1);
        n_cmp++; if (obs0.size() != 3) begin n_bad++; $display("FAIL b2b_count: got %0d frames want 3", obs0.size()); end
        while (exp0.size() > 0) begin
            e = exp0.pop_front(); n_cmp++;
            if (obs0.size() == 0) begin n_bad++; $display("FAIL b2b_frame: no frame, want d=%h", e.d); end
            else begin
                o = obs0.pop_front();
                if (o !== e) begin n_bad++; $display("FAIL b2b_frame: got d=%h fe=%b pe=%b want d=%h fe=%b pe=%b", o.d, o.fe, o.pe, e.d, e.fe, e.pe); end
            end
        end
        n_cmp++; if (wide0 != 0) begin n_bad++; $display("FAIL rdy_width: got %0d long pulses want 0", wide0); end
        obs0.delete();
    endtask

    task automatic test_reset_mid;
        rec_t        e, o;
        logic [7:0]  ab;
        ab = 8'h5A;
        drive(0, 1'b0); hold(16);
        for (int i = 0; i < 3; i++) begin drive(0, ab[i]); hold(16); end
        drive(0, ab[3]); hold(8);
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({rx_data0, rx_rdy0, fe0, pe0, busy0} !== 12'h000) begin
            n_bad++; $display("FAIL reset_mid_outputs: got %h want 000", {rx_data0, rx_rdy0, fe0, pe0, busy0});
        end
        drive(0, 1'b0);
        hold(5);
        rst_n = 1'b1;
        hold(40);
        n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL reset_low_busy: got %b want 0", busy0); end
        n_cmp++; if (obs0.size() != 0) begin n_bad++; $display("FAIL reset_abandon: got %0d frames want 0", obs0.size()); end
        obs0.delete();
        drive(0, 1'b1); hold(20);
        send(0, 9'h05A, 8, 1'b0, 1'b0, 1'b1, GLITCH);
        for (int k = 0; k < 300 && obs0.size() < exp0.size(); k++) hold(1);
        while (exp0.size() > 0) begin
            e = exp0.pop_front(); n_cmp++;
            if (obs0.size() == 0) begin n_bad++; $display("FAIL reset_next_frame: no frame, want d=%h", e.d); end
            else begin
                o = obs0.pop_front();
                if (o !== e) begin n_bad++; $display("FAIL reset_next_frame: got d=%h fe=%b pe=%b want d=%h fe=%b pe=%b", o.d, o.fe, o.pe, e.d, e.fe, e.pe); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_frame_err();
        test_parity();
        test_false_start();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- Parametrised, oversampling UART receiver; next generation of the team's fixed-rate 8N1 receiver.
- Runs on the system clock with a programmable clocks-per-bit ratio.
- Supports 5–9 data bits and optional odd/even parity.
- Detects start glitches and reports framing/parity errors.
- Sits between the pad synchroniser-less rx pin and the byte-stream consumer (command parser / FIFO).

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit; legal range >= 4. HALF = CLKS_PER_BIT/2 (integer division).
- DATA_BITS, 8, data bits per frame; legal range 5..9; LSB first on the line.
- PARITY_EN, 0, 1 = a parity bit follows the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN = 0.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- rx_in  input  1  serial line, idle high, asynchronous to clk.
- rx_data  output  DATA_BITS  last received word; held until the next frame completes.
- rx_rdy  output  1  single-cycle pulse: rx_data, frame_err and parity_err updated.
- frame_err  output  1  stop bit sampled 0 for the frame flagged by rx_rdy; held.
- parity_err  output  1  parity mismatch for the frame flagged by rx_rdy; held; always 0 when PARITY_EN = 0.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Input path
  - rx_in passes through a 2-flop synchroniser (rx_s) inside the block.
  - Synchroniser flops and a previous-sample flop reset to 0.
  - Start is detected only on a falling edge of rx_s (prev = 1, rx_s = 0). A line held low through reset release never produces a frame.
- Counters
  - cnt: baud counter, 0..CLKS_PER_BIT-1.
  - idx: bit index, 0..DATA_BITS-1.
- State machine: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on falling edge of rx_s -> START, cnt = 0.
  - START: cnt increments. At cnt == HALF-1, sample rx_s.
    - Sample = 1: false start -> IDLE; no outputs change.
    - Sample = 0: cnt = 0, idx = 0 -> DATA.
  - DATA: at cnt == CLKS_PER_BIT-1, shift the sampled bit into a shift register at position idx (LSB first) and clear cnt.
    - After bit DATA_BITS-1 -> PARITY if PARITY_EN, else STOP.
  - PARITY: at cnt == CLKS_PER_BIT-1, capture the parity bit and clear cnt -> STOP.
  - STOP: at cnt == CLKS_PER_BIT-1, sample the stop bit, then on the next clock edge:
    - rx_data <= shift register.
    - frame_err <= ~stop.
    - parity_err <= (XOR of data ^ parity bit ^ PARITY_ODD) != 0, evaluated only when PARITY_EN.
    - rx_rdy <= 1 for exactly one cycle.
    - -> IDLE.
  - Returning at the stop-bit midpoint lets back-to-back frames with a single stop bit be received with no loss.
- Errors: frames with errors still update rx_data and pulse rx_rdy; the consumer decides whether to discard.
- Flag lifetime: frame_err and parity_err are rewritten on every rx_rdy; they do not accumulate.
- Reset values: rx_data = 0, rx_rdy = 0, frame_err = 0, parity_err = 0, busy = 0, state = IDLE, cnt = 0, idx = 0.
- Reset mid-frame: the frame is abandoned immediately; no rx_rdy for it; the FSM waits for a fresh falling edge.
- Illegal state encodings -> IDLE.

Optional Feature:
- Macro UART_RX_MAJORITY_EN.
- When defined:
  - A 3-bit history of rx_s is kept.
  - Every sample point (start check, data, parity, stop) uses the 2-of-3 majority of the last three rx_s values instead of the single rx_s value.
  - A 1-cycle glitch at a sample point is rejected.
- When undefined: single-sample at each point; no history register synthesised.
- Timing and latency are identical in both builds.

Test Plan:
- Default params, send 0xA5 (start, bits 1,0,1,0,0,1,0,1, stop 1) at 16 clk/bit. Required response:
  - rx_rdy pulses once.
  - rx_rdy rises 152..156 clk after rx_in falls.
  - rx_data = 0xA5, frame_err = 0, parity_err = 0.
  - busy high throughout the frame.
- Stop bit driven 0 on byte 0x3C -> rx_data = 0x3C, frame_err = 1 with rx_rdy; next clean 0x55 -> frame_err = 0.
- PARITY_EN = 1, PARITY_ODD = 0, DATA_BITS = 7:
  - Send 0x41 with parity 0 -> parity_err = 0.
  - Resend with parity 1 -> parity_err = 1.
- rx_in low pulse of 3 clk while idle -> returns to IDLE at the HALF-1 sample; rx_rdy never asserts; busy falls within 12 clk.
- Three frames 0x00, 0xFF, 0x81 back-to-back with one stop bit -> three rx_rdy pulses in order with those values, no frame_err.
- rst_n asserted mid-DATA of a frame:
  - All outputs 0 asynchronously; no rx_rdy for the abandoned frame.
  - rx_in held low across reset release produces no frame.
  - A following 0x5A frame is received correctly.
  - With UART_RX_MAJORITY_EN: an added 1-clk inverted glitch at each data midpoint still yields 0x5A.
